// File: rtl/powlib_sfifo_if.sv
// Write/read valid-ready handshake bundle for powlib_sfifo.
// The slave modport is the FIFO side; the master modport is the producer/consumer side.
interface powlib_sfifo_if #(
    parameter int W = 32
);
    logic [W-1:0] wrdata;
    logic         wrvld;
    logic         wrrdy;
    logic [W-1:0] rddata;
    logic         rdvld;
    logic         rdrdy;

    modport master (output wrdata, wrvld, rdrdy, input wrrdy, rddata, rdvld);
    modport slave  (input wrdata, wrvld, rdrdy, output wrrdy, rddata, rdvld);
endinterface

// File: rtl/powlib_sfifo.sv
// Single-clock FIFO: D-entry array plus one registered read stage (D+1 words total).
// Define POWLIB_SFIFO_ALMOST_EN to add the afull/aempty outputs driven from cnt.
module powlib_sfifo #(
    parameter int W  = 32,
    parameter int D  = 4,
    parameter int AF = D - 1,
    parameter int AE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    powlib_sfifo_if.slave          bus,
    output logic [$clog2(D+2)-1:0] cnt
`ifdef POWLIB_SFIFO_ALMOST_EN
    ,
    output logic                   afull,
    output logic                   aempty
`endif
);
    localparam int AW = $clog2(D);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(D + 2);

    logic [W-1:0]  mem [D];
    logic [PW-1:0] wrptr, rdptr, ramcnt;
    logic [W-1:0]  rddata_q;
    logic          rdvld_q;
    logic          wrrdy, wr, iss, pop;

    // Pointers carry an extra wrap bit so full (D) and empty (0) differ.
    assign ramcnt = wrptr - rdptr;
    assign wrrdy  = (ramcnt != PW'(D));
    assign wr     = bus.wrvld & wrrdy;
    assign iss    = (ramcnt != '0) & (!rdvld_q | bus.rdrdy);
    assign pop    = rdvld_q & bus.rdrdy;

    assign bus.wrrdy  = wrrdy;
    assign bus.rdvld  = rdvld_q;
    assign bus.rddata = rddata_q;

    // Array is never reset; stale entries become unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr) mem[wrptr[AW-1:0]] <= bus.wrdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrptr    <= '0;
            rdptr    <= '0;
            rdvld_q  <= 1'b0;
            rddata_q <= '0;
            cnt      <= '0;
        end else begin
            if (wr) wrptr <= wrptr + 1'b1;
            if (iss) begin
                rddata_q <= mem[rdptr[AW-1:0]];
                rdvld_q  <= 1'b1;
                rdptr    <= rdptr + 1'b1;
            end else if (bus.rdrdy) begin
                rdvld_q  <= 1'b0;
            end
            cnt <= cnt + CW'(wr) - CW'(pop);
        end
    end

`ifdef POWLIB_SFIFO_ALMOST_EN
    assign afull  = (int'(cnt) >= AF);
    assign aempty = (int'(cnt) <= AE);
`endif
endmodule

// File: tb/tb_powlib_sfifo.sv
// Self-checking bench for powlib_sfifo; reference model is a queue of accepted words.
module tb_powlib_sfifo;
    localparam int W = 32;
    localparam int D = 4;
    localparam int CW = $clog2(D + 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [CW-1:0] cnt;
`ifdef POWLIB_SFIFO_ALMOST_EN
    logic afull, aempty;
`endif

    powlib_sfifo_if #(.W(W)) bus ();

    powlib_sfifo #(.W(W), .D(D), .AF(3), .AE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .cnt   (cnt)
`ifdef POWLIB_SFIFO_ALMOST_EN
        ,
        .afull (afull),
        .aempty(aempty)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        bus.wrvld = 1'b0;
        bus.wrdata = '0;
        bus.rdrdy = 1'b0;
        rst_n = 1'b0;
        q.delete();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset_wrrdy", {31'd0, bus.wrrdy}, 32'd1);
        chk("reset_rdvld", {31'd0, bus.rdvld}, 32'd0);
        chk("reset_rddata", bus.rddata, 32'd0);
        chk("reset_cnt", {29'd0, cnt}, 32'd0);
`ifdef POWLIB_SFIFO_ALMOST_EN
        chk("reset_afull", {31'd0, afull}, 32'd0);
        chk("reset_aempty", {31'd0, aempty}, 32'd1);
`endif
    endtask

    task automatic test_first_word();
        do_reset();
        bus.wrvld = 1'b1;
        bus.wrdata = 32'h1234;
        bus.rdrdy = 1'b1;
        chk("fw_cnt_c0", {29'd0, cnt}, 32'd0);
        cyc();
        bus.wrvld = 1'b0;
        chk("fw_cnt_c1", {29'd0, cnt}, 32'd1);
        chk("fw_rdvld_c1", {31'd0, bus.rdvld}, 32'd0);
        cyc();
        chk("fw_rdvld_c2", {31'd0, bus.rdvld}, 32'd1);
        chk("fw_rddata_c2", bus.rddata, 32'h1234);
        chk("fw_cnt_c2", {29'd0, cnt}, 32'd1);
        cyc();
        chk("fw_cnt_c3", {29'd0, cnt}, 32'd0);
        chk("fw_rdvld_c3", {31'd0, bus.rdvld}, 32'd0);
    endtask

    task automatic test_full();
        logic [W-1:0] words [6];
        int acc;
        int got;
        words = '{32'h1234, 32'h5678, 32'hCBA9, 32'h0FED, 32'h1111, 32'h2222};
        do_reset();
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.wrvld = 1'b1;
            bus.wrdata = words[i];
            if (bus.wrrdy) acc++;
            cyc();
        end
        bus.wrvld = 1'b0;
        chk("full_accepted", acc, 32'd5);
        chk("full_cnt", {29'd0, cnt}, 32'd5);
        chk("full_wrrdy", {31'd0, bus.wrrdy}, 32'd0);
        bus.rdrdy = 1'b1;
        got = 0;
        for (int t = 0; t < 50 && got < 5; t++) begin
            if (bus.rdvld) begin
                chk("full_drain_data", bus.rddata, words[got]);
                got++;
            end
            cyc();
        end
        chk("full_drain_count", got, 32'd5);
        chk("full_drain_cnt", {29'd0, cnt}, 32'd0);
        chk("full_drain_rdvld", {31'd0, bus.rdvld}, 32'd0);
        bus.rdrdy = 1'b0;
    endtask

    task automatic test_stream();
        int got;
        do_reset();
        bus.rdrdy = 1'b1;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            bus.wrvld = (c < 20);
            bus.wrdata = c;
            if (c == 2) chk("stream_first_rdvld", {31'd0, bus.rdvld}, 32'd1);
            if (c >= 2 && c < 20) chk("stream_cnt", {29'd0, cnt}, 32'd2);
            if (c < 20) chk("stream_wrrdy", {31'd0, bus.wrrdy}, 32'd1);
            if (bus.rdvld) begin
                chk("stream_data", bus.rddata, got);
                chk("stream_slot", c, got + 2);
                got++;
            end
            cyc();
        end
        bus.wrvld = 1'b0;
        chk("stream_total", got, 32'd20);
    endtask

    task automatic test_random();
        int acc;
        int outn;
        logic prev_stall;
        logic [W-1:0] prev_data;
        logic wr, pop;
        do_reset();
        acc = 0;
        outn = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        for (int t = 0; t < 20000 && (acc < 1000 || q.size() != 0); t++) begin
            bus.wrvld = (acc < 1000) && ($urandom_range(0, 3) != 0);
            bus.wrdata = $urandom();
            bus.rdrdy = ($urandom_range(0, 1) != 0);
            if (prev_stall) begin
                chk("rand_stall_vld", {31'd0, bus.rdvld}, 32'd1);
                chk("rand_stall_data", bus.rddata, prev_data);
            end
            chk("rand_wrrdy", {31'd0, bus.wrrdy}, {31'd0, q.size() != D + 1});
            wr = bus.wrvld && bus.wrrdy;
            pop = bus.rdvld && bus.rdrdy;
            if (bus.rdvld) begin
                if (q.size() == 0) chk("rand_vld_when_empty", 32'd1, 32'd0);
                else chk("rand_order", bus.rddata, q[0]);
            end
            if (pop && q.size() != 0) begin
                void'(q.pop_front());
                outn++;
            end
            if (wr) begin
                q.push_back(bus.wrdata);
                acc++;
            end
            prev_stall = bus.rdvld && !bus.rdrdy;
            prev_data = bus.rddata;
            cyc();
            chk("rand_cnt", {29'd0, cnt}, q.size());
        end
        bus.wrvld = 1'b0;
        bus.rdrdy = 1'b0;
        chk("rand_in_total", acc, 32'd1000);
        chk("rand_out_total", outn, 32'd1000);
    endtask

    task automatic test_async_reset();
        int got;
        do_reset();
        bus.rdrdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wrvld = 1'b1;
            bus.wrdata = 32'hA000 + i;
            cyc();
        end
        bus.wrvld = 1'b0;
        chk("ar_cnt_before", {29'd0, cnt}, 32'd3);
        chk("ar_rddata_before", bus.rddata, 32'hA000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rdvld", {31'd0, bus.rdvld}, 32'd0);
        chk("ar_cnt", {29'd0, cnt}, 32'd0);
        chk("ar_rddata", bus.rddata, 32'd0);
        cyc();
        rst_n = 1'b1;
        bus.wrvld = 1'b1;
        bus.wrdata = 32'h0000ABCD;
        bus.rdrdy = 1'b1;
        cyc();
        bus.wrvld = 1'b0;
        got = 0;
        for (int t = 0; t < 10 && got == 0; t++) begin
            if (bus.rdvld) begin
                chk("ar_after_data", bus.rddata, 32'h0000ABCD);
                got = 1;
            end
            cyc();
        end
        chk("ar_after_seen", got, 32'd1);
        chk("ar_after_cnt", {29'd0, cnt}, 32'd0);
    endtask

`ifdef POWLIB_SFIFO_ALMOST_EN
    task automatic test_almost();
        int n;
        do_reset();
        bus.rdrdy = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            chk("alm_afull", {31'd0, afull}, {31'd0, n >= 3});
            chk("alm_aempty", {31'd0, aempty}, {31'd0, n <= 1});
            bus.wrvld = 1'b1;
            bus.wrdata = i;
            if (bus.wrrdy) n++;
            cyc();
        end
        bus.wrvld = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_first_word();
        test_full();
        test_stream();
        test_random();
        test_async_reset();
`ifdef POWLIB_SFIFO_ALMOST_EN
        test_almost();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/powlib_sfifo.md
# powlib_sfifo

Synchronous single-clock FIFO that drives a W×D dual-port memory with one write port and one registered read port, sitting directly upstream of the dual-port RAM. It accepts words on a valid/ready write interface, stores them in the memory array, and presents them in order on a valid/ready read interface through a registered read stage. Total capacity is D+1 words: D in the array plus one in the read register.

## Interface
Parameters:
- W, 32, data width in bits.
- D, 4, array depth in words; power of two, ≥ 2.
- AF, D-1, almost-full threshold. Used only with POWLIB_SFIFO_ALMOST_EN.
- AE, 1, almost-empty threshold. Used only with POWLIB_SFIFO_ALMOST_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- wrdata  in  W  write data.
- wrvld  in  1  write valid.
- wrrdy  out  1  write ready.
- rddata  out  W  read data (registered).
- rdvld  out  1  read valid.
- rdrdy  in  1  read ready.
- cnt  out  $clog2(D+2)  total words held (array + read register).
- afull  out  1  present only with POWLIB_SFIFO_ALMOST_EN; high when cnt ≥ AF.
- aempty  out  1  present only with POWLIB_SFIFO_ALMOST_EN; high when cnt ≤ AE.

## Operation
- State:
  - wrptr, rdptr: $clog2(D)+1 bits each; the MSB is the wrap bit.
  - ramcnt = wrptr − rdptr, range 0..D.
  - rdvld register.
  - rddata register.
  - cnt register.
- Write accept (wr) = wrvld & wrrdy.
  - wrrdy = (ramcnt != D), driven directly from registers.
  - On wr: mem[wrptr[low]] ← wrdata, then wrptr + 1.
- Read issue (iss) = (ramcnt != 0) & (!rdvld | rdrdy).
  - On iss: rddata ← mem[rdptr[low]], rdvld ← 1, rdptr + 1.
  - Else if rdrdy: rdvld ← 0; rddata holds.
- Pop = rdvld & rdrdy.
- cnt update: cnt ← cnt + wr − pop.
- Pointer arithmetic is modulo 2·D, so it wraps naturally. Full/empty are distinguished by the wrap bit.
- Read-during-write:
  - No bypass. A word written on an edge is readable no earlier than the next cycle.
  - iss and wr never target the same entry: empty blocks reads, and full blocks writes.
- Write while full is ignored. wrdata is not stored and no pointer moves.
- Read while empty: rdvld stays 0 and rddata holds its last value.
- Simultaneous wr and pop at any occupancy: cnt is unchanged.
- Reset asserted mid-operation, asynchronously:
  - pointers → 0, cnt → 0, rdvld → 0, rddata → 0.
  - Array contents are not cleared; they are unreachable after reset.

## Timing
- Reset values:
  - wrrdy = 1
  - rdvld = 0
  - rddata = 0
  - cnt = 0
  - afull = (AF == 0)
  - aempty = 1
- First-word latency is 2 cycles. A word accepted in cycle 0 gives ramcnt = 1 and iss in cycle 1, and rdvld = 1 with the word on rddata in cycle 2.
- Throughput: 1 word/cycle sustained in both directions with rdrdy held high. A read is issued in the same cycle as the pop that frees the register.
- rdvld and rddata hold stable while rdvld & !rdrdy.
- wrrdy deasserts the cycle after the D-th array entry is written. It reasserts the cycle after the next iss.
- afull and aempty are combinational from cnt.

## Configuration
- Macro: POWLIB_SFIFO_ALMOST_EN.
  - Defined: the afull/aempty ports exist and parameters AF/AE take effect.
  - Undefined: the afull/aempty ports and their logic are absent, and AF/AE are ignored.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then write 0x1234 in cycle 0 with rdrdy = 1 → rdvld = 1 and rddata = 0x1234 in cycle 2; cnt goes 0→1→1→0.
- D = 4, rdrdy = 0, write 0x1234, 0x5678, 0xCBA9, 0x0FED, 0x1111, 0x2222 back-to-back → wrrdy drops after 5 accepted words (4 array + 1 register); cnt = 5; 0x2222 is not stored. Draining returns the 5 accepted words in order.
- Continuous stream of 0..19 with wrvld = rdrdy = 1 → one word out per cycle after the 2-cycle fill; order preserved across pointer wrap; cnt steady at 2.
- Random rdrdy backpressure over 1000 random words → rddata stable while stalled; output sequence equals the accepted input sequence.
- Assert rst_n low mid-stream with cnt = 3 → rdvld, cnt and rddata go to 0 immediately without waiting for clk; after release, the first new write reads back correctly.
- With POWLIB_SFIFO_ALMOST_EN, AF = 3, AE = 1 → afull rises exactly when cnt reaches 3; aempty is high at cnt = 0 and 1 and low at cnt = 2.
